// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch stage with a small prefetch queue.
// The PC fetches from a combinational instruction memory into a DEPTH-entry
// queue of {instruction, PC+2}. Decode pops from the head, and a later
// stage can redirect the PC and flush the queue.
// Optional feature macro: IF_JUMP_PREDECODE_EN. When it is defined, jump
// opcodes are recognised at fetch and the PC follows them immediately.
module if_prefetch #(
  parameter int              XLEN    = 16,
  parameter int              DEPTH   = 4,
  parameter int              OP_W    = 4,
  parameter logic [OP_W-1:0] JUMP_OP = 4'hF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             redirect,
  input  logic [XLEN-1:0]                  redirect_addr,
  output logic [XLEN-1:0]                  imem_addr,
  input  logic [XLEN-1:0]                  imem_data,
  output logic                             imem_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_ins,
  output logic [XLEN-1:0]                  out_npc,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

`ifdef IF_JUMP_PREDECODE_EN
  localparam bit JUMP_PREDECODE = 1'b1;
`else
  localparam bit JUMP_PREDECODE = 1'b0;
`endif

  logic [XLEN-1:0]  r_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [XLEN-1:0]  r_insQ [DEPTH];
  logic [XLEN-1:0]  r_npcQ [DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic [XLEN-1:0]  w_pcPlus2;
  logic             w_isJump;
  logic             w_takeJump;
  logic [XLEN-1:0]  w_jumpTarget;
  logic [XLEN-1:0]  w_nextPc;

  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & out_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign w_push    = ~redirect & ((r_count < CNT_W'(DEPTH)) | w_pop);
  assign w_pcPlus2 = r_pc + XLEN'(2);

  // The jump target keeps the PC's upper page bits and takes the low offset
  // from the instruction, shifted to a halfword address.
  assign w_isJump     = (imem_data[XLEN-1:XLEN-OP_W] == JUMP_OP);
  assign w_takeJump   = JUMP_PREDECODE & w_isJump;
  assign w_jumpTarget = {r_pc[XLEN-1:XLEN-OP_W+1], imem_data[XLEN-OP_W-1:0], 1'b0};

  assign imem_addr = r_pc;
  assign imem_en   = w_push;
  assign out_valid = w_valid;
  assign out_ins   = w_valid ? r_insQ[r_head] : '0;
  assign out_npc   = w_valid ? r_npcQ[r_head] : '0;
  assign count     = r_count;

  // Next PC: a redirect beats a predecoded jump, which beats sequential fetch.
  always_comb begin
    w_nextPc = r_pc;
    if (redirect) begin
      w_nextPc = redirect_addr & ~XLEN'(1);
    end else if (w_push && w_takeJump) begin
      w_nextPc = w_jumpTarget;
    end else if (w_push) begin
      w_nextPc = w_pcPlus2;
    end
  end

  // Queue storage; entries need no reset because count gates their visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_insQ[r_tail] <= imem_data;
      r_npcQ[r_tail] <= w_pcPlus2;
    end
  end

  // PC, pointers and occupancy; a redirect flushes the queue and drops any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (redirect) begin
      r_pc    <= w_nextPc;
      r_count <= '0;
      r_head  <= r_tail;
    end else begin
      r_pc <= w_nextPc;
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Testbench for if_prefetch: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the fetch stage.
module tb_if_prefetch;

  localparam int XLEN  = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            imem_en;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_ins;
  logic [XLEN-1:0] out_npc;
  logic [CW-1:0]   count;

  logic [15:0] mem [65536];

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: the PC and a queue of {instruction, npc}.
  int          mPc;
  logic [31:0] mQ[$];

  if_prefetch dut (
    .clk           (clk),
    .rst           (rst),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_en       (imem_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ins       (out_ins),
    .out_npc       (out_npc),
    .count         (count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory.
  assign imem_data = mem[imem_addr];

  // Where the PC goes after fetching ins at pc, ignoring redirects.
  function automatic int nextPcAfterFetch(int pc, logic [15:0] ins);
`ifdef IF_JUMP_PREDECODE_EN
    if (ins[15:12] == 4'hF) return (pc & 'hE000) | ((ins & 'h0FFF) << 1);
`endif
    return (pc + 2) & 'hFFFF;
  endfunction

  // A fetch is accepted unless redirecting, when there is room or the head leaves.
  function automatic bit modelPush();
    return !redirect && ((mQ.size() < DEPTH) || ((mQ.size() != 0) && out_ready));
  endfunction

  task automatic modelReset();
    mQ.delete();
    mPc = 0;
  endtask

  // Advance one clock edge, moving the model the same way, then settle.
  task automatic tick();
    bit          doPush = modelPush();
    bit          doPop  = (mQ.size() != 0) && out_ready;
    bit          doRedir = redirect;
    int          rAddr  = int'(redirect_addr);
    logic [15:0] ins    = mem[mPc];
    @(posedge clk);
    if (doRedir) begin
      mQ.delete();
      mPc = rAddr & 'hFFFE;
    end else begin
      if (doPop) void'(mQ.pop_front());
      if (doPush) begin
        mQ.push_back({ins, 16'((mPc + 2) & 'hFFFF)});
        mPc = nextPcAfterFetch(mPc, ins);
      end
    end
    #1;
  endtask

  task automatic applyReset();
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_addr = '0;
    out_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    redirect      = 1'b0;
    redirect_addr = '0;
    out_ready     = 1'b0;
    rst           = 1'b1;
    #1;
    nCompared++;
    if (imem_addr !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_addr: got %h want 0000", imem_addr); end
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
    nCompared++;
    if (out_ins !== 16'h0000 || out_npc !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_out: got ins %h npc %h want 0000 0000", out_ins, out_npc); end
    nCompared++;
    if (count !== CW'(0)) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    applyReset();
  endtask

  task automatic test_sequential();
    applyReset();
    out_ready = 1'b1;
    #1;
    nCompared++;
    if (imem_addr !== 16'h0000 || imem_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL seq_first_fetch: got addr %h en %b want 0000 1", imem_addr, imem_en); end
    tick();
    nCompared++;
    if (out_valid !== 1'b1 || out_ins !== 16'h1000 || out_npc !== 16'h0002) begin nMismatched++; $display("[TB] FAIL seq_first_out: got v %b ins %h npc %h want 1 1000 0002", out_valid, out_ins, out_npc); end
    nCompared++;
    if (imem_addr !== 16'h0002) begin nMismatched++; $display("[TB] FAIL seq_addr2: got %h want 0002", imem_addr); end
    tick();
    nCompared++;
    if (imem_addr !== 16'h0004 || out_ins !== 16'h1001 || count !== CW'(1)) begin nMismatched++; $display("[TB] FAIL seq_addr4: got addr %h ins %h cnt %0d want 0004 1001 1", imem_addr, out_ins, count); end
  endtask

  task automatic test_backpressure();
    applyReset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    nCompared++;
    if (count !== CW'(4)) begin nMismatched++; $display("[TB] FAIL bp_count: got %0d want 4", count); end
    nCompared++;
    if (imem_en !== 1'b0 || imem_addr !== 16'h0008) begin nMismatched++; $display("[TB] FAIL bp_hold: got en %b addr %h want 0 0008", imem_en, imem_addr); end
    out_ready = 1'b1;
    #1;
    nCompared++;
    if (imem_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_full_push: got en %b want 1", imem_en); end
    tick();
    nCompared++;
    if (count !== CW'(4) || out_ins !== 16'h1001 || out_npc !== 16'h0004 || imem_addr !== 16'h000A) begin
      nMismatched++;
      $display("[TB] FAIL bp_push_pop: got cnt %0d ins %h npc %h addr %h want 4 1001 0004 000a", count, out_ins, out_npc, imem_addr);
    end
  endtask

  task automatic test_redirect();
    applyReset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    nCompared++;
    if (count !== CW'(3)) begin nMismatched++; $display("[TB] FAIL redir_fill: got %0d want 3", count); end
    out_ready     = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'h0125;
    #1;
    nCompared++;
    if (imem_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL redir_no_push: got en %b want 0", imem_en); end
    tick();
    redirect = 1'b0;
    #1;
    nCompared++;
    if (count !== CW'(0) || out_valid !== 1'b0 || imem_addr !== 16'h0124) begin
      nMismatched++;
      $display("[TB] FAIL redir_flush: got cnt %0d v %b addr %h want 0 0 0124", count, out_valid, imem_addr);
    end
    tick();
    nCompared++;
    if (out_ins !== mem[16'h0124] || out_npc !== 16'h0126) begin nMismatched++; $display("[TB] FAIL redir_target: got ins %h npc %h want %h 0126", out_ins, out_npc, mem[16'h0124]); end
  endtask

  task automatic test_jump();
    logic [15:0] wantPc;
`ifdef IF_JUMP_PREDECODE_EN
    wantPc = 16'hA246;
`else
    wantPc = 16'hA012;
`endif
    applyReset();
    out_ready     = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'hA010;
    tick();
    redirect = 1'b0;
    #1;
    nCompared++;
    if (imem_addr !== 16'hA010 || imem_data !== 16'hF123) begin nMismatched++; $display("[TB] FAIL jump_setup: got addr %h data %h want a010 f123", imem_addr, imem_data); end
    tick();
    nCompared++;
    if (imem_addr !== wantPc) begin nMismatched++; $display("[TB] FAIL jump_next_pc: got %h want %h", imem_addr, wantPc); end
    nCompared++;
    if (out_ins !== 16'hF123 || out_npc !== 16'hA012) begin nMismatched++; $display("[TB] FAIL jump_queued: got ins %h npc %h want f123 a012", out_ins, out_npc); end
  endtask

  task automatic test_wrap();
    applyReset();
    out_ready     = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 16'hFFFF;
    tick();
    redirect = 1'b0;
    #1;
    nCompared++;
    if (imem_addr !== 16'hFFFE) begin nMismatched++; $display("[TB] FAIL wrap_pc: got %h want fffe", imem_addr); end
    tick();
    nCompared++;
    if (out_npc !== 16'h0000 || imem_addr !== 16'h0000 || out_ins !== 16'h8FFF) begin
      nMismatched++;
      $display("[TB] FAIL wrap_npc: got npc %h addr %h ins %h want 0000 0000 8fff", out_npc, imem_addr, out_ins);
    end
  endtask

  task automatic test_async_reset();
    applyReset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    nCompared++;
    if (count !== CW'(4)) begin nMismatched++; $display("[TB] FAIL areset_fill: got %0d want 4", count); end
    #2;
    rst = 1'b1;
    #1;
    nCompared++;
    if (count !== CW'(0) || out_valid !== 1'b0 || imem_addr !== 16'h0000 || out_ins !== 16'h0000 || out_npc !== 16'h0000) begin
      nMismatched++;
      $display("[TB] FAIL areset_clear: got cnt %0d v %b addr %h ins %h npc %h want all 0", count, out_valid, imem_addr, out_ins, out_npc);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    out_ready = 1'b1;
    #1;
    nCompared++;
    if (imem_addr !== 16'h0000 || imem_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL areset_refetch: got addr %h en %b want 0000 1", imem_addr, imem_en); end
    tick();
    nCompared++;
    if (out_ins !== 16'h1000 || count !== CW'(1)) begin nMismatched++; $display("[TB] FAIL areset_first: got ins %h cnt %0d want 1000 1", out_ins, count); end
  endtask

  task automatic test_random();
    logic [15:0] wantIns;
    logic [15:0] wantNpc;
    applyReset();
    for (int i = 0; i < 300; i++) begin
      out_ready     = ($urandom_range(0, 2) != 0);
      redirect      = ($urandom_range(0, 11) == 0);
      redirect_addr = 16'($urandom_range(0, 65535));
      #1;
      nCompared++;
      if (imem_en !== modelPush()) begin nMismatched++; $display("[TB] FAIL rnd_en[%0d]: got %b want %b", i, imem_en, modelPush()); end
      tick();
      wantIns = (mQ.size() != 0) ? mQ[0][31:16] : 16'h0000;
      wantNpc = (mQ.size() != 0) ? mQ[0][15:0]  : 16'h0000;
      nCompared++;
      if (imem_addr !== 16'(mPc) || count !== CW'(mQ.size()) || out_valid !== (mQ.size() != 0) ||
          out_ins !== wantIns || out_npc !== wantNpc) begin
        nMismatched++;
        $display("[TB] FAIL rnd_state[%0d]: got addr %h cnt %0d v %b ins %h npc %h want %h %0d %b %h %h",
                 i, imem_addr, count, out_valid, out_ins, out_npc, 16'(mPc), mQ.size(), (mQ.size() != 0), wantIns, wantNpc);
      end
    end
    redirect = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(16'h1000 + (a >> 1));
    mem[16'hA010] = 16'hF123;
    modelReset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_jump();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 16: instruction, PC and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries; a power of two, at least 2.
REQ-003 SHALL have parameter OP_W, default 4: opcode field width, occupying ins[XLEN-1:XLEN-OP_W].
REQ-004 SHALL have parameter JUMP_OP, default 4'hF: opcode value that marks a jump.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port redirect, input, 1 bit: branch taken, from a later stage.
REQ-008 SHALL have port redirect_addr, input, XLEN bits: the branch target.
REQ-009 SHALL have port imem_addr, output, XLEN bits: fetch address, always equal to PC.
REQ-010 SHALL have port imem_data, input, XLEN bits: instruction at imem_addr, combinational read.
REQ-011 SHALL have port imem_en, output, 1 bit: a fetch is accepted this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: decode accepts the head.
REQ-014 SHALL have port out_ins, output, XLEN bits: the head instruction.
REQ-015 SHALL have port out_npc, output, XLEN bits: the head's fetch PC + 2.
REQ-016 SHALL have port count, output, clog2(DEPTH+1) bits: queue occupancy.

Function
REQ-017 SHALL define pop = out_valid & out_ready and push = imem_en.
REQ-018 SHALL drive imem_en = !redirect & (count < DEPTH | pop), so a push is allowed into a full queue in the same cycle as a pop.
REQ-019 SHALL write {imem_data, PC+2} at the tail on push; PC+2 wraps modulo 2^XLEN.
REQ-020 SHALL update PC with this priority: redirect gives {redirect_addr[XLEN-1:1],0}; else a push of a jump gives the jump target (REQ-031); else a push gives PC+2; else PC holds.
REQ-021 SHALL, on redirect, empty the queue (count=0, head=tail), push nothing, and discard any coincident pop.
REQ-022 SHALL present the head combinationally on out_ins/out_npc while out_valid=1, and drive both to 0 when count=0.
REQ-023 SHALL drive out_valid = (count != 0).
REQ-024 SHALL return a fetched instruction on out_* no earlier than the cycle after its push (one-cycle latency).
REQ-025 SHALL wrap the head and tail pointers modulo DEPTH.
REQ-026 SHALL change count by +1 on push only, -1 on pop only, and 0 on push with pop.
REQ-027 SHALL force PC[0] to 0 at all times.

Reset
REQ-028 SHALL, while rst=1, clear immediately, independent of clk: PC=0, count=0, head=0, tail=0.
REQ-029 SHALL hold these reset output values: imem_addr=0, out_valid=0, out_ins=0, out_npc=0, count=0.
REQ-030 SHALL, on rst asserted mid-operation, drop all queued entries; the first fetch after release is from address 0.

Configuration
REQ-031 SHALL, with macro IF_JUMP_PREDECODE_EN defined, decode jumps at fetch: when imem_data[XLEN-1:XLEN-OP_W]==JUMP_OP and it is pushed, the instruction SHALL be queued and the next PC SHALL be {PC[XLEN-1:XLEN-OP_W+1], imem_data[XLEN-OP_W-1:0], 0}.
REQ-032 SHALL, without IF_JUMP_PREDECODE_EN, treat jump opcodes as ordinary instructions (PC+2); the downstream stage resolves the jump via redirect.

Verification
REQ-033 SHALL verify: reset release, out_ready=1, imem holds 0x1000,0x1001,... -> imem_addr 0,2,4; out_ins 0x1000 with out_npc 0x0002 one cycle after the first push.
REQ-034 SHALL verify: out_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4, imem_en=0, PC holds 0x0008; then out_ready=1 -> push and pop occur in the same cycle and count stays 4.
REQ-035 SHALL verify: redirect=1, redirect_addr=0x0125, queue holding 3 entries -> the next cycle has count=0 and PC=0x0124; the cycle after has out_ins=imem[0x0124].
REQ-036 SHALL verify: IF_JUMP_PREDECODE_EN defined, PC=0xA010, imem_data=0xF123 -> the jump is queued and the next PC is 0xA246; with the macro undefined the next PC is 0xA012.
REQ-037 SHALL verify: PC=0xFFFE fetched -> out_npc=0x0000 and the next PC is 0x0000.
REQ-038 SHALL verify: rst pulsed between clock edges with the queue full -> the outputs clear immediately, before the next clk edge.
